// File: rtl/mux2to1_reg_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mux2to1_reg_if
//   Bundles the data/select/valid signals of mux2to1_reg.
//
//   a, b       WIDTH  data inputs (a when sel=0, b when sel=1)
//   sel        1      select
//   in_valid   1      qualifies a/b/sel for the registered path
//   y          WIDTH  combinational select result
//   y_q        WIDTH  registered select result
//   out_valid  1      y_q holds a valid result
//
//   master: the side that drives the inputs and observes the results.
//   slave : the selector itself.
// -----------------------------------------------------------------------------
interface mux2to1_reg_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sel;
    logic             in_valid;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] y_q;
    logic             out_valid;

    modport master (
        output a, b, sel, in_valid,
        input  y, y_q, out_valid
    );

    modport slave (
        input  a, b, sel, in_valid,
        output y, y_q, out_valid
    );
endinterface

// File: rtl/mux2to1_reg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mux2to1_reg
//   2-to-1 selector with a combinational output and a registered, validated
//   copy delayed by LATENCY clocks.
//
//   clk   in  rising-edge clock
//   rst   in  asynchronous, active-high reset (clears the whole pipeline)
//   bus   slave modport of mux2to1_reg_if:
//         a, b, sel, in_valid in; y, y_q, out_valid out
//
//   Parameters: WIDTH (>=1) data width, LATENCY (1..4) register stages.
// -----------------------------------------------------------------------------
module mux2to1_reg #(
    parameter int WIDTH   = 1,
    parameter int LATENCY = 1
) (
    input  logic          clk,
    input  logic          rst,
    mux2to1_reg_if.slave  bus
);

    generate
        if (WIDTH < 1 || LATENCY < 1 || LATENCY > 4) begin : g_param_check
            $error("mux2to1_reg: WIDTH must be >=1 and LATENCY must be 1..4");
        end
    endgenerate

    logic [WIDTH-1:0]   stage0_data_d;
    logic               stage0_vld_d;
    logic [WIDTH-1:0]   data_q [LATENCY];
    logic [LATENCY-1:0] vld_q;

    // Shared select feeds both the glue-logic output and the first stage.
    always_comb begin
        stage0_data_d = bus.sel ? bus.b : bus.a;
        stage0_vld_d  = bus.in_valid;
    end

    assign bus.y = stage0_data_d;

    // Data loads every cycle regardless of in_valid; out_valid alone
    // qualifies y_q downstream. Reset discards anything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < LATENCY; k++) begin
                data_q[k] <= '0;
            end
            vld_q <= '0;
        end else begin
            data_q[0] <= stage0_data_d;
            vld_q[0]  <= stage0_vld_d;
            for (int k = 1; k < LATENCY; k++) begin
                data_q[k] <= data_q[k-1];
                vld_q[k]  <= vld_q[k-1];
            end
        end
    end

    assign bus.y_q       = data_q[LATENCY-1];
    assign bus.out_valid = vld_q[LATENCY-1];

endmodule

// File: tb/tb_mux2to1_reg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_mux2to1_reg
//   Bench for mux2to1_reg: a WIDTH=1/LATENCY=1 instance for the combinational
//   truth table, and WIDTH=8 instances at LATENCY=1 and LATENCY=3 driven with
//   identical stimulus and compared against a capture-history model.
// -----------------------------------------------------------------------------
module tb_mux2to1_reg;

    logic clk = 1'b0;
    logic rst;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    mux2to1_reg_if #(.WIDTH(1)) bus1 ();
    mux2to1_reg_if #(.WIDTH(8)) bus8a ();
    mux2to1_reg_if #(.WIDTH(8)) bus8c ();

    mux2to1_reg #(.WIDTH(1), .LATENCY(1)) u_w1  (.clk(clk), .rst(rst), .bus(bus1));
    mux2to1_reg #(.WIDTH(8), .LATENCY(1)) u_l1  (.clk(clk), .rst(rst), .bus(bus8a));
    mux2to1_reg #(.WIDTH(8), .LATENCY(3)) u_l3  (.clk(clk), .rst(rst), .bus(bus8c));

    // Reference model: every rising edge outside reset captures the selected
    // value and in_valid; an output of latency L shows the capture made L-1
    // edges ago, or zero if fewer than L captures have happened since reset.
    typedef struct {
        logic [7:0] d;
        logic       v;
    } cap_t;
    cap_t hist[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hist.delete();
        end else begin
            hist.push_back('{d: (bus8a.sel ? bus8a.b : bus8a.a), v: bus8a.in_valid});
            if (hist.size() > 8) void'(hist.pop_front());
        end
    end

    function automatic logic [7:0] exp_d(int lat);
        if (hist.size() >= lat) return hist[hist.size()-lat].d;
        return 8'h00;
    endfunction

    function automatic logic exp_v(int lat);
        if (hist.size() >= lat) return hist[hist.size()-lat].v;
        return 1'b0;
    endfunction

    task automatic drive8(input logic [7:0] a, input logic [7:0] b,
                          input logic s, input logic v);
        bus8a.a = a; bus8a.b = b; bus8a.sel = s; bus8a.in_valid = v;
        bus8c.a = a; bus8c.b = b; bus8c.sel = s; bus8c.in_valid = v;
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        n_total++; if (bus1.y_q !== 1'b0 || bus1.out_valid !== 1'b0)
            $display("FAIL reset_w1 got y_q=%b ov=%b want 0/0", bus1.y_q, bus1.out_valid); else n_pass++;
        n_total++; if (bus8a.y_q !== 8'h00 || bus8a.out_valid !== 1'b0)
            $display("FAIL reset_l1 got y_q=%h ov=%b want 00/0", bus8a.y_q, bus8a.out_valid); else n_pass++;
        n_total++; if (bus8c.y_q !== 8'h00 || bus8c.out_valid !== 1'b0)
            $display("FAIL reset_l3 got y_q=%h ov=%b want 00/0", bus8c.y_q, bus8c.out_valid); else n_pass++;
    endtask

    task automatic test_reset_y();
        logic s;
        bus1.a = 1'b0; bus1.b = 1'b1; bus1.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s = i[0];
            bus1.sel = s;
            #7;
            n_total++; if (bus1.y !== s)
                $display("FAIL reset_y_track got %b want %b", bus1.y, s); else n_pass++;
            n_total++; if (bus1.y_q !== 1'b0 || bus1.out_valid !== 1'b0)
                $display("FAIL reset_yq_hold got y_q=%b ov=%b want 0/0", bus1.y_q, bus1.out_valid); else n_pass++;
        end
    endtask

    task automatic test_exhaustive_y();
        logic [7:0] table_y;
        logic [2:0] abs;
        table_y = 8'b1101_1000; // bit i = required y for {a,b,sel}=i
        for (int i = 0; i < 8; i++) begin
            abs = i[2:0];
            bus1.a = abs[2]; bus1.b = abs[1]; bus1.sel = abs[0];
            #10;
            n_total++; if (bus1.y !== table_y[i])
                $display("FAIL exhaustive_y i=%0d got %b want %b", i, bus1.y, table_y[i]); else n_pass++;
        end
    endtask

    task automatic test_single_l1();
        drive8(8'h3C, 8'hA5, 1'b1, 1'b1);
        edge_sample();
        n_total++; if (bus8a.y_q !== 8'hA5 || bus8a.out_valid !== 1'b1)
            $display("FAIL single_l1 got y_q=%h ov=%b want a5/1", bus8a.y_q, bus8a.out_valid); else n_pass++;
        drive8(8'h3C, 8'hA5, 1'b1, 1'b0);
        edge_sample();
        n_total++; if (bus8a.out_valid !== 1'b0)
            $display("FAIL single_l1_drop got ov=%b want 0", bus8a.out_valid); else n_pass++;
    endtask

    task automatic test_stream_l3();
        logic [7:0] want [4];
        want[0] = 8'h11; want[1] = 8'h22; want[2] = 8'h11; want[3] = 8'h22;
        drive8(8'h11, 8'h22, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) edge_sample();
        for (int e = 1; e <= 7; e++) begin
            if (e <= 4) drive8(8'h11, 8'h22, (e % 2) == 0, 1'b1);
            else        drive8(8'h11, 8'h22, 1'b0, 1'b0);
            edge_sample();
            if (e >= 3 && e <= 6) begin
                n_total++; if (bus8c.y_q !== want[e-3] || bus8c.out_valid !== 1'b1)
                    $display("FAIL stream_l3 edge%0d got y_q=%h ov=%b want %h/1",
                             e, bus8c.y_q, bus8c.out_valid, want[e-3]); else n_pass++;
            end else begin
                n_total++; if (bus8c.out_valid !== 1'b0)
                    $display("FAIL stream_l3_idle edge%0d got ov=%b want 0", e, bus8c.out_valid); else n_pass++;
            end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            drive8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b1);
            edge_sample();
        end
        n_total++; if (bus8c.out_valid !== 1'b1)
            $display("FAIL pre_reset_l3 got ov=%b want 1", bus8c.out_valid); else n_pass++;
        drive8(8'h00, 8'h00, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        n_total++; if (bus8c.y_q !== 8'h00 || bus8c.out_valid !== 1'b0)
            $display("FAIL async_reset_l3 got y_q=%h ov=%b want 00/0", bus8c.y_q, bus8c.out_valid); else n_pass++;
        n_total++; if (bus8a.y_q !== 8'h00 || bus8a.out_valid !== 1'b0)
            $display("FAIL async_reset_l1 got y_q=%h ov=%b want 00/0", bus8a.y_q, bus8a.out_valid); else n_pass++;
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            edge_sample();
            n_total++; if (bus8c.out_valid !== 1'b0)
                $display("FAIL post_reset_l3 edge%0d got ov=%b want 0", i + 1, bus8c.out_valid); else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [7:0] ra, rb;
        logic       rs, rv;
        for (int c = 0; c < 300; c++) begin
            ra = 8'($urandom); rb = 8'($urandom);
            rs = 1'($urandom_range(0, 1)); rv = 1'($urandom_range(0, 1));
            drive8(ra, rb, rs, rv);
            #1;
            n_total++; if (bus8a.y !== (rs ? rb : ra))
                $display("FAIL rand_y c=%0d got %h want %h", c, bus8a.y, rs ? rb : ra); else n_pass++;
            edge_sample();
            n_total++; if (bus8a.y_q !== exp_d(1) || bus8a.out_valid !== exp_v(1))
                $display("FAIL rand_l1 c=%0d got %h/%b want %h/%b",
                         c, bus8a.y_q, bus8a.out_valid, exp_d(1), exp_v(1)); else n_pass++;
            n_total++; if (bus8c.y_q !== exp_d(3) || bus8c.out_valid !== exp_v(3))
                $display("FAIL rand_l3 c=%0d got %h/%b want %h/%b",
                         c, bus8c.y_q, bus8c.out_valid, exp_d(3), exp_v(3)); else n_pass++;
            if ($urandom_range(0, 39) == 0) begin
                #2 rst = 1'b1;
                #1;
                n_total++; if (bus8c.y_q !== 8'h00 || bus8c.out_valid !== 1'b0)
                    $display("FAIL rand_reset_l3 c=%0d got %h/%b want 00/0",
                             c, bus8c.y_q, bus8c.out_valid); else n_pass++;
                #1 rst = 1'b0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus1.a = 1'b0; bus1.b = 1'b0; bus1.sel = 1'b0; bus1.in_valid = 1'b0;
        drive8(8'h00, 8'h00, 1'b0, 1'b0);
        test_reset();
        test_reset_y();
        test_exhaustive_y();
        @(negedge clk);
        rst = 1'b0;
        test_single_l1();
        test_stream_l3();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
